// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the MSC-16 two-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_AW = 16;
  localparam int unsigned DEF_DW = 16;

  localparam logic PORT_IFETCH = 1'b0;
  localparam logic PORT_LSU    = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    CAPT  = 3'd3,
    RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-requester round-robin picker; gnt is one-hot or zero.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // A tie goes to the port that is not 'last'; a lone request wins outright.
  always_comb begin
    gnt = req;
    if (&req) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the MSC-16 memory port between instruction fetch (port 0) and
// load/store (port 1); one transaction in flight, sequenced through the
// controller's fixed read latency.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW        = DEF_AW,
  parameter int unsigned DW        = DEF_DW,
  parameter int unsigned READ_WAIT = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          p0_valid,
  output logic          p0_ready,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_done,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_valid,
  output logic          p1_ready,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_done,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned   CW        = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(READ_WAIT - 1);

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic            port_q, port_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            p0_done_q, p0_done_d;
  logic            p1_done_q, p1_done_d;
  logic [DW-1:0]   p0_rdata_q, p0_rdata_d;
  logic [DW-1:0]   p1_rdata_q, p1_rdata_d;

  logic [1:0]      req;
  logic [1:0]      gnt;

  assign req = {p1_valid, p0_valid};

  rr_arb2 u_rr_arb2 (
    .req  (req),
    .last (last_q),
    .gnt  (gnt)
  );

  // Grants are only offered while idle.
  assign p0_ready = (state_q == IDLE) & gnt[0];
  assign p1_ready = (state_q == IDLE) & gnt[1];

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    port_d      = port_q;
    cnt_d       = cnt_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    p0_done_d   = 1'b0;
    p1_done_d   = 1'b0;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;

    case (state_q)
      IDLE: begin
        if (|gnt) begin
          port_d      = gnt[1] ? PORT_LSU : PORT_IFETCH;
          if (&req) begin
            last_d = gnt[1] ? PORT_LSU : PORT_IFETCH;
          end
          mem_en_d    = 1'b1;
          mem_we_d    = gnt[1] ? p1_we    : p0_we;
          mem_addr_d  = gnt[1] ? p1_addr  : p0_addr;
          mem_wdata_d = gnt[1] ? p1_wdata : p0_wdata;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        mem_we_d = 1'b0;
        if (mem_we_q) begin
          mem_en_d  = 1'b0;
          p0_done_d = (port_q == PORT_IFETCH);
          p1_done_d = (port_q == PORT_LSU);
          state_d   = RESP;
        end else begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = CAPT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CAPT: begin
        // Read data is only sampled while the controller is still enabled.
        if (port_q == PORT_LSU) begin
          p1_rdata_d = mem_rdata;
        end else begin
          p0_rdata_d = mem_rdata;
        end
        mem_en_d  = 1'b0;
        p0_done_d = (port_q == PORT_IFETCH);
        p1_done_d = (port_q == PORT_LSU);
        state_d   = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      last_q      <= PORT_LSU;
      port_q      <= PORT_IFETCH;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      p0_done_q   <= 1'b0;
      p1_done_q   <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      port_q      <= port_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      p0_done_q   <= p0_done_d;
      p1_done_q   <= p1_done_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign p0_done   = p0_done_q;
  assign p1_done   = p1_done_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of the MSC-16 memory controller. It shares the single 16-bit memory port between instruction fetch (port 0) and load/store (port 1) using round-robin arbitration. It sequences each granted access through the controller's fixed read latency and returns read data or a write acknowledge to the winning port. Only one transaction is outstanding at a time.

## Interface
Parameters:
- AW, 16, address width
- DW, 16, data width
- READ_WAIT, 1, number of WAIT cycles between ISSUE and CAPT; 1 matches the BRAM plus controller output register

Ports:
- clk  in  1  system clock
- rstn  in  1  reset; one clock, synchronous, active-low
- p0_valid / p1_valid  in  1  request valid
- p0_ready / p1_ready  out  1  request accepted this cycle
- p0_we / p1_we  in  1  1 = write, 0 = read
- p0_addr / p1_addr  in  AW  word address
- p0_wdata / p1_wdata  in  DW  write data
- p0_done / p1_done  out  1  one-cycle completion pulse, for reads and writes
- p0_rdata / p1_rdata  out  DW  read data, valid while pN_done=1 for a read
- mem_en  out  1  controller enable
- mem_we  out  1  controller write enable
- mem_addr  out  AW  controller address
- mem_wdata  out  DW  controller write data
- mem_rdata  in  DW  controller read data

## Operation
- **Output registering:** all outputs are registered except pN_ready, which is combinational from state and valids.
- **Reset values:** mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, pN_done=0, pN_rdata=0, state=IDLE, last=1 (port 0 wins the first tie).
- **Request handshake:** a transfer is accepted when pN_valid & pN_ready at a rising edge. The requester holds valid and its payload stable until ready. At most one pN_ready is high in any cycle.
- **Arbitration (IDLE only):**
  - Only one valid: that port gets ready.
  - Both valid: the port ≠ last gets ready, and last is updated to that port on accept.
  - last is unchanged when only one port requests.
- **States:**
  - IDLE: ready is possible. Accept → latch port id, we, addr, wdata → ISSUE.
  - ISSUE: mem_en=1, mem_we=we, mem_addr, mem_wdata driven. Write → RESP. Read → WAIT.
  - WAIT: mem_en=1, mem_we=0. Stays READ_WAIT cycles (internal counter), then → CAPT.
  - CAPT: mem_en=1, mem_we=0. Latches mem_rdata into the granted port's rdata → RESP.
  - RESP: pN_done=1 for the granted port, mem_en=0 → IDLE.
- **mem_en hold:** the controller tri-states its read data while en=0, so mem_en stays high from ISSUE through CAPT for reads. rdata is never sampled with en low.
- **Data transparency:** byte-lane handling belongs to the controller. The arbiter passes addr, wdata and rdata unmodified.
- **Non-granted port:** pN_rdata of the non-granted port holds its previous value.
- **Reset mid-operation:** the next edge with rstn=0 forces IDLE and the reset values. No done pulse is issued for the aborted transaction. Requesters must re-request.

## Timing
- **Read:** accept at edge T; ISSUE in cycle T+1; WAIT in T+2; CAPT in T+3; done plus rdata in T+4; next accept possible at the end of T+5. Latency is 4 cycles + (READ_WAIT−1).
- **Write:** accept at T; ISSUE (memory written at the end of T+1); done in T+2; next accept possible at the end of T+3.
- **Sustained throughput:** one read per 5 cycles, one write per 3 cycles.
- **Back-to-back requests:** a requester may raise valid in the same cycle its done is high. It is considered only once the FSM returns to IDLE.
- **Continuous dual requests:** both valids held high → strict alternation 0,1,0,1 starting with port 0 after reset.

## Structure
- Package mem_arb_pkg holds:
  - the state encoding (IDLE, ISSUE, WAIT, CAPT, RESP), 3 bits;
  - port-id constants PORT_IFETCH=0, PORT_LSU=1;
  - default AW/DW.
- One sub-module, rr_arb2: a combinational two-requester round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: gnt[1:0] one-hot.
  - The top instantiates it and gates gnt with state==IDLE to form pN_ready.

## Test plan
- **Single read:** reset; memory[0x0010]=0xBEEF; p0 reads 0x0010 → p0_ready at T, mem_en high T+1..T+3, p0_done and p0_rdata=0xBEEF at T+4, p1_done stays 0.
- **Write then read:** p1 writes 0x1234 to 0x00A0 → mem_we=1 only in T+1, p1_done at T+2; p1 then reads 0x00A0 → p1_rdata=0x1234.
- **Simultaneous requests:** both valid from reset, holding constant reads (0x0001, 0x0002) → grant order 0,1,0,1; each done carries the correct port's data; never two readies in one cycle.
- **Single-requester fairness:** only p1 requesting for 3 transactions, then both → p0 is granted first (last=1).
- **Reset mid-read:** rstn=0 during WAIT → next edge mem_en=0, state IDLE, no pN_done; after release a new p0 read completes normally.
- **Payload hold:** p0 valid held high, with addr held stable, while p1 is being served → p0 is accepted in the first IDLE cycle and mem_addr matches the held address.
